// File: rtl/mmu_tlb_if.sv
`default_nettype none
// ============================================================================
// Module   : mmu_tlb_if
// Brief    : Translation request/result and TLB management bundle for mmu_tlb.
// Revision : 1.0 - initial release
// ============================================================================
interface mmu_tlb_if #(
    parameter int IDX_W = 4
);
    logic [7:0]       asid;
    logic             i_req;
    logic [31:0]      i_vaddr;
    logic             i_valid;
    logic [31:0]      i_paddr;
    logic             i_uncached;
    logic             i_refill;
    logic             i_invalid;
    logic             d_req;
    logic             d_we;
    logic [31:0]      d_vaddr;
    logic             d_valid;
    logic [31:0]      d_paddr;
    logic             d_uncached;
    logic             d_refill;
    logic             d_invalid;
    logic             d_modified;
    logic [1:0]       tlb_op;
    logic [IDX_W-1:0] tlb_index;
    logic [31:0]      tlb_entryhi;
    logic [31:0]      tlb_entrylo0;
    logic [31:0]      tlb_entrylo1;
    logic             tlb_done;
    logic [31:0]      tlbp_index;
    logic [31:0]      r_entryhi;
    logic [31:0]      r_entrylo0;
    logic [31:0]      r_entrylo1;

    modport master (
        output asid, i_req, i_vaddr, d_req, d_we, d_vaddr,
               tlb_op, tlb_index, tlb_entryhi, tlb_entrylo0, tlb_entrylo1,
        input  i_valid, i_paddr, i_uncached, i_refill, i_invalid,
               d_valid, d_paddr, d_uncached, d_refill, d_invalid, d_modified,
               tlb_done, tlbp_index, r_entryhi, r_entrylo0, r_entrylo1
    );

    modport slave (
        input  asid, i_req, i_vaddr, d_req, d_we, d_vaddr,
               tlb_op, tlb_index, tlb_entryhi, tlb_entrylo0, tlb_entrylo1,
        output i_valid, i_paddr, i_uncached, i_refill, i_invalid,
               d_valid, d_paddr, d_uncached, d_refill, d_invalid, d_modified,
               tlb_done, tlbp_index, r_entryhi, r_entrylo0, r_entrylo1
    );
endinterface
`default_nettype wire

// File: rtl/mmu_tlb.sv
`default_nettype none
// ============================================================================
// Module   : mmu_tlb
// Brief    : Dual-port (fetch/data) MIPS-style address translation with a
//            fully-associative TLB, present only when MMU_TLB_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module mmu_tlb #(
    parameter int TLB_ENTRIES = 16,
    parameter int IDX_W       = 4
) (
    input logic      clk,
    input logic      reset,
    mmu_tlb_if.slave bus
);
    localparam logic [1:0]  c_OP_PROBE   = 2'b10;
    localparam logic [1:0]  c_OP_READ    = 2'b11;
    localparam logic [31:0] c_PROBE_MISS = 32'h8000_0000;

    typedef struct packed {
        logic [31:0] paddr;
        logic        uncached;
        logic        refill;
        logic        invalid;
        logic        modified;
    } res_t;

    function automatic logic is_mapped(input logic [31:0] va);
        return va[31:30] != 2'b10;
    endfunction

    // kseg0/kseg1 strip their base; mapped segments pass through unless the TLB overrides them.
    function automatic res_t seg_xlate(input logic [31:0] va);
        res_t r;
        r       = '0;
        r.paddr = va;
        if (va[31:29] == 3'b100) begin
            r.paddr = {va[31:28] - 4'h8, va[27:0]};
        end else if (va[31:29] == 3'b101) begin
            r.paddr    = {va[31:28] - 4'hA, va[27:0]};
            r.uncached = 1'b1;
        end
        return r;
    endfunction

    res_t        w_i_res;
    res_t        w_d_res;
    logic [31:0] w_probe;
    logic [31:0] w_rd_hi;
    logic [31:0] w_rd_lo0;
    logic [31:0] w_rd_lo1;
    logic        w_unused;

    res_t        r_i_res;
    res_t        r_d_res;
    logic        r_i_valid;
    logic        r_d_valid;
    logic        r_done;
    logic [31:0] r_tlbp;
    logic [31:0] r_rd_hi;
    logic [31:0] r_rd_lo0;
    logic [31:0] r_rd_lo1;

`ifdef MMU_TLB_EN
    localparam logic [1:0]       c_OP_WRITE = 2'b01;
    localparam logic [IDX_W:0]   c_ENTRIES  = (IDX_W + 1)'(TLB_ENTRIES);

    typedef struct packed {
        logic [19:0] pfn;
        logic [2:0]  c;
        logic        d;
        logic        v;
    } lo_t;

    logic [18:0] r_vpn2 [TLB_ENTRIES];
    logic [7:0]  r_asid [TLB_ENTRIES];
    logic        r_g    [TLB_ENTRIES];
    lo_t         r_lo0  [TLB_ENTRIES];
    lo_t         r_lo1  [TLB_ENTRIES];

    logic [TLB_ENTRIES-1:0] w_i_hit;
    logic [TLB_ENTRIES-1:0] w_d_hit;
    logic [TLB_ENTRIES-1:0] w_p_hit;
    logic [IDX_W-1:0]       w_i_idx;
    logic [IDX_W-1:0]       w_d_idx;
    logic [IDX_W-1:0]       w_p_idx;
    lo_t                    w_i_lo;
    lo_t                    w_d_lo;
    logic                   w_idx_ok;

    for (genvar k = 0; k < TLB_ENTRIES; k++) begin : g_match
        assign w_i_hit[k] = (r_vpn2[k] == bus.i_vaddr[31:13]) &&
                            (r_g[k] || (r_asid[k] == bus.asid));
        assign w_d_hit[k] = (r_vpn2[k] == bus.d_vaddr[31:13]) &&
                            (r_g[k] || (r_asid[k] == bus.asid));
        assign w_p_hit[k] = (r_vpn2[k] == bus.tlb_entryhi[31:13]) &&
                            (r_g[k] || (r_asid[k] == bus.tlb_entryhi[7:0]));
    end

    // Scanning downward leaves the lowest matching index as the winner.
    function automatic logic [IDX_W-1:0] first_hit(input logic [TLB_ENTRIES-1:0] hit);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int k = TLB_ENTRIES - 1; k >= 0; k--) begin
            if (hit[k]) idx = IDX_W'(k);
        end
        return idx;
    endfunction

    function automatic res_t tlb_xlate(input logic [31:0] va, input logic store,
                                       input logic hit, input lo_t lo);
        res_t r;
        r = '0;
        if (!hit) begin
            r.refill = 1'b1;
        end else if (!lo.v) begin
            r.invalid = 1'b1;
        end else if (store && !lo.d) begin
            r.modified = 1'b1;
        end else begin
            r.paddr    = {lo.pfn, va[11:0]};
            r.uncached = (lo.c == 3'b010);
        end
        return r;
    endfunction

    always_comb begin
        w_i_idx  = first_hit(w_i_hit);
        w_d_idx  = first_hit(w_d_hit);
        w_p_idx  = first_hit(w_p_hit);
        w_i_lo   = bus.i_vaddr[12] ? r_lo1[w_i_idx] : r_lo0[w_i_idx];
        w_d_lo   = bus.d_vaddr[12] ? r_lo1[w_d_idx] : r_lo0[w_d_idx];
        w_i_res  = seg_xlate(bus.i_vaddr);
        w_d_res  = seg_xlate(bus.d_vaddr);
        if (is_mapped(bus.i_vaddr)) w_i_res = tlb_xlate(bus.i_vaddr, 1'b0, |w_i_hit, w_i_lo);
        if (is_mapped(bus.d_vaddr)) w_d_res = tlb_xlate(bus.d_vaddr, bus.d_we, |w_d_hit, w_d_lo);
        w_probe  = (|w_p_hit) ? {{(32 - IDX_W){1'b0}}, w_p_idx} : c_PROBE_MISS;
        w_idx_ok = ({1'b0, bus.tlb_index} < c_ENTRIES);
        w_rd_hi  = '0;
        w_rd_lo0 = '0;
        w_rd_lo1 = '0;
        if (w_idx_ok) begin
            w_rd_hi  = {r_vpn2[bus.tlb_index], 5'b0, r_asid[bus.tlb_index]};
            w_rd_lo0 = {6'b0, r_lo0[bus.tlb_index], r_g[bus.tlb_index]};
            w_rd_lo1 = {6'b0, r_lo1[bus.tlb_index], r_g[bus.tlb_index]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < TLB_ENTRIES; k++) begin
                r_vpn2[k] <= '0;
                r_asid[k] <= '0;
                r_g[k]    <= 1'b0;
                r_lo0[k]  <= '0;
                r_lo1[k]  <= '0;
            end
        end else if ((bus.tlb_op == c_OP_WRITE) && w_idx_ok) begin
            r_vpn2[bus.tlb_index] <= bus.tlb_entryhi[31:13];
            r_asid[bus.tlb_index] <= bus.tlb_entryhi[7:0];
            r_g[bus.tlb_index]    <= bus.tlb_entrylo0[0] & bus.tlb_entrylo1[0];
            r_lo0[bus.tlb_index]  <= bus.tlb_entrylo0[25:1];
            r_lo1[bus.tlb_index]  <= bus.tlb_entrylo1[25:1];
        end
    end

    assign w_unused = ^{bus.tlb_entryhi[12:8], bus.tlb_entrylo0[31:26],
                        bus.tlb_entrylo1[31:26], r_i_res.modified};
`else
    always_comb begin
        w_i_res  = seg_xlate(bus.i_vaddr);
        w_d_res  = seg_xlate(bus.d_vaddr);
        w_probe  = c_PROBE_MISS;
        w_rd_hi  = '0;
        w_rd_lo0 = '0;
        w_rd_lo1 = '0;
    end

    assign w_unused = ^{bus.asid, bus.d_we, bus.tlb_index, bus.tlb_entryhi,
                        bus.tlb_entrylo0, bus.tlb_entrylo1, r_i_res.modified};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_i_valid <= 1'b0;
            r_i_res   <= '0;
            r_d_valid <= 1'b0;
            r_d_res   <= '0;
            r_done    <= 1'b0;
            r_tlbp    <= '0;
            r_rd_hi   <= '0;
            r_rd_lo0  <= '0;
            r_rd_lo1  <= '0;
        end else begin
            r_i_valid <= bus.i_req;
            r_i_res   <= bus.i_req ? w_i_res : '0;
            r_d_valid <= bus.d_req;
            r_d_res   <= bus.d_req ? w_d_res : '0;
            r_done    <= (bus.tlb_op != 2'b00);
            if (bus.tlb_op == c_OP_PROBE) r_tlbp <= w_probe;
            if (bus.tlb_op == c_OP_READ) begin
                r_rd_hi  <= w_rd_hi;
                r_rd_lo0 <= w_rd_lo0;
                r_rd_lo1 <= w_rd_lo1;
            end
        end
    end

    // Reset masks the registered results at once so an in-flight result is never observed.
    assign bus.i_valid    = r_i_valid & ~reset;
    assign bus.i_paddr    = reset ? '0 : r_i_res.paddr;
    assign bus.i_uncached = r_i_res.uncached & ~reset;
    assign bus.i_refill   = r_i_res.refill & ~reset;
    assign bus.i_invalid  = r_i_res.invalid & ~reset;
    assign bus.d_valid    = r_d_valid & ~reset;
    assign bus.d_paddr    = reset ? '0 : r_d_res.paddr;
    assign bus.d_uncached = r_d_res.uncached & ~reset;
    assign bus.d_refill   = r_d_res.refill & ~reset;
    assign bus.d_invalid  = r_d_res.invalid & ~reset;
    assign bus.d_modified = r_d_res.modified & ~reset;
    assign bus.tlb_done   = r_done & ~reset;
    assign bus.tlbp_index = reset ? '0 : r_tlbp;
    assign bus.r_entryhi  = reset ? '0 : r_rd_hi;
    assign bus.r_entrylo0 = reset ? '0 : r_rd_lo0;
    assign bus.r_entrylo1 = reset ? '0 : r_rd_lo1;
endmodule
`default_nettype wire

// File: tb/tb_mmu_tlb.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmu_tlb
// Brief    : Directed plus randomized bench for mmu_tlb against an
//            address-level reference model (honours MMU_TLB_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmu_tlb;
    localparam int N  = 12;
    localparam int IW = 4;
`ifdef MMU_TLB_EN
    localparam bit TLB_ON = 1'b1;
`else
    localparam bit TLB_ON = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pa;
        logic        unc;
        logic        rf;
        logic        inv;
        logic        md;
    } xr_t;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mmu_tlb_if #(.IDX_W(IW)) bus ();
    mmu_tlb #(.TLB_ENTRIES(N), .IDX_W(IW)) dut (.clk(clk), .reset(reset), .bus(bus));

    // Reference state: the raw EntryHi/EntryLo words as software would read them back.
    logic [31:0] m_hi  [N];
    logic [31:0] m_lo0 [N];
    logic [31:0] m_lo1 [N];
    logic        started = 1'b0;
    logic        e_iv, e_dv, e_done;
    xr_t         e_i, e_d;
    logic [31:0] e_tlbp, e_rhi, e_rlo0, e_rlo1;
    logic [31:0] pool [7] = '{32'h0040_0000, 32'h0040_2000, 32'h7FFF_E000, 32'hC000_0000,
                              32'hE000_4000, 32'h9000_0000, 32'hB000_0000};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int find(input logic [31:0] va, input logic [7:0] a);
        if (!TLB_ON) return -1;
        for (int i = 0; i < N; i++)
            if (m_hi[i][31:13] == va[31:13] && (m_lo0[i][0] || m_hi[i][7:0] == a)) return i;
        return -1;
    endfunction

    function automatic xr_t model_xlate(input logic [31:0] va, input logic store, input logic [7:0] a);
        xr_t         r;
        int          h;
        logic [31:0] lo;
        r = '0;
        if (va >= 32'h8000_0000 && va < 32'hA000_0000) begin
            r.pa = va - 32'h8000_0000;
        end else if (va >= 32'hA000_0000 && va < 32'hC000_0000) begin
            r.pa  = va - 32'hA000_0000;
            r.unc = 1'b1;
        end else if (!TLB_ON) begin
            r.pa = va;
        end else begin
            h = find(va, a);
            if (h < 0) begin
                r.rf = 1'b1;
            end else begin
                lo = va[12] ? m_lo1[h] : m_lo0[h];
                if (!lo[1]) r.inv = 1'b1;
                else if (store && !lo[2]) r.md = 1'b1;
                else begin
                    r.pa  = {lo[25:6], va[11:0]};
                    r.unc = (lo[5:3] == 3'd2);
                end
            end
        end
        return r;
    endfunction

    always @(posedge clk) begin
        int   k;
        logic g;
        started <= 1'b1;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_hi[i] <= '0; m_lo0[i] <= '0; m_lo1[i] <= '0;
            end
            e_iv <= 1'b0; e_dv <= 1'b0; e_i <= '0; e_d <= '0; e_done <= 1'b0;
            e_tlbp <= '0; e_rhi <= '0; e_rlo0 <= '0; e_rlo1 <= '0;
        end else begin
            e_iv   <= bus.i_req;
            e_i    <= bus.i_req ? model_xlate(bus.i_vaddr, 1'b0, bus.asid) : '0;
            e_dv   <= bus.d_req;
            e_d    <= bus.d_req ? model_xlate(bus.d_vaddr, bus.d_we, bus.asid) : '0;
            e_done <= (bus.tlb_op != 2'b00);
            if (bus.tlb_op == 2'b10) begin
                k = find(bus.tlb_entryhi, bus.tlb_entryhi[7:0]);
                e_tlbp <= (k < 0) ? 32'h8000_0000 : k;
            end
            if (bus.tlb_op == 2'b11) begin
                if (TLB_ON && int'(bus.tlb_index) < N) begin
                    e_rhi  <= m_hi[bus.tlb_index];
                    e_rlo0 <= m_lo0[bus.tlb_index];
                    e_rlo1 <= m_lo1[bus.tlb_index];
                end else begin
                    e_rhi <= '0; e_rlo0 <= '0; e_rlo1 <= '0;
                end
            end
            if (TLB_ON && bus.tlb_op == 2'b01 && int'(bus.tlb_index) < N) begin
                g = bus.tlb_entrylo0[0] & bus.tlb_entrylo1[0];
                m_hi[bus.tlb_index]  <= bus.tlb_entryhi & 32'hFFFF_E0FF;
                m_lo0[bus.tlb_index] <= (bus.tlb_entrylo0 & 32'h03FF_FFFE) | {31'b0, g};
                m_lo1[bus.tlb_index] <= (bus.tlb_entrylo1 & 32'h03FF_FFFE) | {31'b0, g};
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            if (reset) begin
                chk("rst_flags", {bus.i_valid, bus.i_uncached, bus.i_refill, bus.i_invalid,
                                  bus.d_valid, bus.d_uncached, bus.d_refill, bus.d_invalid,
                                  bus.d_modified, bus.tlb_done}, 32'd0);
                chk("rst_paddr", bus.i_paddr | bus.d_paddr, 32'd0);
                chk("rst_mgmt", bus.tlbp_index | bus.r_entryhi | bus.r_entrylo0 | bus.r_entrylo1, 32'd0);
            end else begin
                chk("i_valid", bus.i_valid, e_iv);
                chk("i_refill", bus.i_refill, e_i.rf);
                chk("i_invalid", bus.i_invalid, e_i.inv);
                if (!e_i.inv) begin
                    chk("i_paddr", bus.i_paddr, e_i.pa);
                    chk("i_uncached", bus.i_uncached, e_i.unc);
                end
                chk("d_valid", bus.d_valid, e_dv);
                chk("d_refill", bus.d_refill, e_d.rf);
                chk("d_invalid", bus.d_invalid, e_d.inv);
                chk("d_modified", bus.d_modified, e_d.md);
                if (!(e_d.inv || e_d.md)) begin
                    chk("d_paddr", bus.d_paddr, e_d.pa);
                    chk("d_uncached", bus.d_uncached, e_d.unc);
                end
                chk("tlb_done", bus.tlb_done, e_done);
                chk("tlbp_index", bus.tlbp_index, e_tlbp);
                chk("r_entryhi", bus.r_entryhi, e_rhi);
                chk("r_entrylo0", bus.r_entrylo0, e_rlo0);
                chk("r_entrylo1", bus.r_entrylo1, e_rlo1);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.i_req = 1'b0; bus.i_vaddr = '0; bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_vaddr = '0;
        bus.tlb_op = 2'b00; bus.tlb_index = '0;
        bus.tlb_entryhi = '0; bus.tlb_entrylo0 = '0; bus.tlb_entrylo1 = '0;
    endtask

    task automatic tlb_cmd(input logic [1:0] op, input logic [IW-1:0] idx, input logic [31:0] hi,
                           input logic [31:0] lo0, input logic [31:0] lo1);
        bus.tlb_op = op; bus.tlb_index = idx;
        bus.tlb_entryhi = hi; bus.tlb_entrylo0 = lo0; bus.tlb_entrylo1 = lo1;
        cyc();
        idle();
    endtask

    task automatic dload(input logic [31:0] va, input logic we);
        bus.d_req = 1'b1; bus.d_vaddr = va; bus.d_we = we;
        cyc();
        idle();
    endtask

    function automatic logic [31:0] rand_va();
        logic [31:0] t;
        t = $urandom();
        if ($urandom_range(0, 4) == 0) return t;
        return {pool[$urandom_range(0, 6)][31:13], t[12:0]};
    endfunction

    initial begin
        logic [31:0] t, lo;
        int          r;
        reset = 1'b1;
        bus.asid = 8'd0;
        idle();
        repeat (2) cyc();
        reset = 1'b0;
        chk("lit_reset_valid", {bus.i_valid, bus.d_valid, bus.tlb_done}, 32'd0);
        chk("lit_reset_tlbp", bus.tlbp_index, 32'd0);

        bus.i_req = 1'b1; bus.i_vaddr = 32'hBFC0_0000;
        cyc(); idle();
        chk("lit_kseg1_valid", bus.i_valid, 32'd1);
        chk("lit_kseg1_paddr", bus.i_paddr, 32'h1FC0_0000);
        chk("lit_kseg1_unc", bus.i_uncached, 32'd1);
        cyc();
        chk("lit_valid_drops", bus.i_valid, 32'd0);

        dload(32'h8000_1234, 1'b0);
        chk("lit_kseg0_valid", bus.d_valid, 32'd1);
        chk("lit_kseg0_paddr", bus.d_paddr, 32'h0000_1234);
        chk("lit_kseg0_unc", bus.d_uncached, 32'd0);

        bus.asid = 8'd5;
`ifdef MMU_TLB_EN
        tlb_cmd(2'b01, 4'd3, 32'h0040_0005, 32'h0000_48DE, 32'h0);
        chk("lit_write_done", bus.tlb_done, 32'd1);
        dload(32'h0040_0ABC, 1'b0);
        chk("lit_hit_paddr", bus.d_paddr, 32'h0012_3ABC);
        dload(32'h0040_1ABC, 1'b0);
        chk("lit_invalid", bus.d_invalid, 32'd1);
        tlb_cmd(2'b01, 4'd3, 32'h0040_0005, 32'h0000_48DA, 32'h0);
        dload(32'h0040_0000, 1'b1);
        chk("lit_modified", bus.d_modified, 32'd1);
        bus.asid = 8'd6;
        dload(32'h0040_0ABC, 1'b0);
        chk("lit_refill", bus.d_refill, 32'd1);
        chk("lit_refill_paddr", bus.d_paddr, 32'd0);
        bus.asid = 8'd5;
        tlb_cmd(2'b10, 4'd0, 32'h0040_0005, 32'h0, 32'h0);
        chk("lit_probe_hit", bus.tlbp_index, 32'd3);
        tlb_cmd(2'b10, 4'd0, 32'h0050_0005, 32'h0, 32'h0);
        chk("lit_probe_miss", bus.tlbp_index, 32'h8000_0000);
        bus.d_req = 1'b1; bus.d_vaddr = 32'h0040_0ABC;
        tlb_cmd(2'b01, 4'd3, 32'h0040_0005, 32'h0001_159E, 32'h0);
        chk("lit_same_cycle_old", bus.d_paddr, 32'h0012_3ABC);
        dload(32'h0040_0ABC, 1'b0);
        chk("lit_new_visible", bus.d_paddr, 32'h0045_6ABC);
        tlb_cmd(2'b11, 4'd3, 32'h0, 32'h0, 32'h0);
        chk("lit_read_hi", bus.r_entryhi, 32'h0040_0005);
        chk("lit_read_lo0", bus.r_entrylo0, 32'h0001_159E);
        tlb_cmd(2'b11, 4'd13, 32'h0, 32'h0, 32'h0);
        chk("lit_read_oob_done", bus.tlb_done, 32'd1);
        chk("lit_read_oob_lo0", bus.r_entrylo0, 32'd0);
        tlb_cmd(2'b11, 4'd3, 32'h0, 32'h0, 32'h0);
        bus.tlb_op = 2'b10; bus.tlb_entryhi = 32'h0040_0005;
        cyc(); idle();
        reset = 1'b1;
        #1;
        chk("lit_reset_kills_done", bus.tlb_done, 32'd0);
        cyc();
        reset = 1'b0;
        tlb_cmd(2'b11, 4'd3, 32'h0, 32'h0, 32'h0);
        chk("lit_cleared_done", bus.tlb_done, 32'd1);
        chk("lit_cleared_hi", bus.r_entryhi, 32'd0);
        chk("lit_cleared_lo0", bus.r_entrylo0, 32'd0);
`else
        dload(32'h0040_0ABC, 1'b1);
        chk("lit_pass_paddr", bus.d_paddr, 32'h0040_0ABC);
        chk("lit_pass_flags", {bus.d_refill, bus.d_invalid, bus.d_modified, bus.d_uncached}, 32'd0);
        tlb_cmd(2'b10, 4'd0, 32'h0040_0005, 32'h0, 32'h0);
        chk("lit_probe_done", bus.tlb_done, 32'd1);
        chk("lit_probe_miss", bus.tlbp_index, 32'h8000_0000);
        tlb_cmd(2'b11, 4'd3, 32'h0, 32'h0, 32'h0);
        chk("lit_read_zero", bus.r_entryhi | bus.r_entrylo0 | bus.r_entrylo1, 32'd0);
        bus.tlb_op = 2'b10;
        cyc(); idle();
        reset = 1'b1;
        #1;
        chk("lit_reset_kills_done", bus.tlb_done, 32'd0);
        cyc();
        reset = 1'b0;
`endif

        for (int n = 0; n < 3000; n++) begin
            reset       = ($urandom_range(0, 149) == 0);
            bus.asid    = ($urandom_range(0, 1) != 0) ? 8'd5 : 8'd6;
            bus.i_req   = ($urandom_range(0, 3) != 0);
            bus.i_vaddr = rand_va();
            bus.d_req   = ($urandom_range(0, 3) != 0);
            bus.d_we    = $urandom_range(0, 1);
            bus.d_vaddr = rand_va();
            r = $urandom_range(0, 9);
            bus.tlb_op    = (r < 3) ? 2'b01 : (r < 4) ? 2'b10 : (r < 5) ? 2'b11 : 2'b00;
            bus.tlb_index = IW'($urandom_range(0, 15));
            t = $urandom();
            bus.tlb_entryhi = {pool[$urandom_range(0, 6)][31:13], t[12:8],
                               (($urandom_range(0, 1) != 0) ? 8'd5 : 8'd6)};
            lo = $urandom();
            lo[1] = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) lo[5:3] = 3'b010;
            bus.tlb_entrylo0 = lo;
            lo = $urandom();
            lo[1] = ($urandom_range(0, 3) != 0);
            lo[0] = bus.tlb_entrylo0[0] & ($urandom_range(0, 1) != 0);
            bus.tlb_entrylo1 = lo;
            cyc();
        end
        reset = 1'b0;
        idle();
        repeat (2) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
